// File: rtl/pc_sequencer_if.sv
// Fetch / issue / next-PC handshake bundle for the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  halt_req_i;
  logic                  imem_req_valid_o;
  logic                  imem_req_ready_i;
  logic [DATA_WIDTH-1:0] imem_addr_o;
  logic                  imem_rsp_valid_i;
  logic [31:0]           imem_rsp_data_i;
  logic                  inst_valid_o;
  logic                  inst_ready_i;
  logic [31:0]           inst_o;
  logic [DATA_WIDTH-1:0] inst_pc_o;
  logic                  pcn_valid_i;
  logic [DATA_WIDTH-1:0] pcn_i;
  logic                  busy_o;
  logic                  misalign_o;
  logic [DATA_WIDTH-1:0] bad_pc_o;
  logic [DATA_WIDTH-1:0] retire_cnt_o;

  // Sequencer side.
  modport master (
    input  halt_req_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    input  inst_ready_i, pcn_valid_i, pcn_i,
    output imem_req_valid_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
    output busy_o, misalign_o, bad_pc_o, retire_cnt_o
  );

  // Environment side (memory, decode, next-PC unit, control).
  modport slave (
    output halt_req_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    output inst_ready_i, pcn_valid_i, pcn_i,
    input  imem_req_valid_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
    input  busy_o, misalign_o, bad_pc_o, retire_cnt_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: fetches one instruction at a time, offers it to decode, waits
// for the next-PC result and retires it. A misaligned target stops the core
// permanently until reset.
module pc_sequencer #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
  input logic            clk_i,
  input logic            rst_n_i,
  pc_sequencer_if.master bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StIssue = 3'd3;
  localparam logic [2:0] StExec  = 3'd4;
  localparam logic [2:0] StHalt  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;
  logic [DATA_WIDTH-1:0] retire_q, retire_d;
  logic                  misalign_q, misalign_d;
  logic [DATA_WIDTH-1:0] bad_pc_q, bad_pc_d;

  // Next-state: one transaction phase per state, inputs outside their phase ignored.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    retire_d   = retire_q;
    misalign_d = misalign_q;
    bad_pc_d   = bad_pc_q;
    case (state_q)
      StIdle: begin
        if (!bus.halt_req_i) state_d = StReq;
      end
      StReq: begin
        if (bus.imem_req_ready_i) state_d = StWait;
      end
      StWait: begin
        if (bus.imem_rsp_valid_i) begin
          ir_d    = bus.imem_rsp_data_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus.inst_ready_i) state_d = StExec;
      end
      StExec: begin
        if (bus.pcn_valid_i) begin
          if (bus.pcn_i[1:0] == 2'b00) begin
            pc_d     = bus.pcn_i;
            retire_d = retire_q + DATA_WIDTH'(1);
            state_d  = bus.halt_req_i ? StIdle : StReq;
          end else begin
            misalign_d = 1'b1;
            bad_pc_d   = bus.pcn_i;
            state_d    = StHalt;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      retire_q   <= '0;
      misalign_q <= 1'b0;
      bad_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      retire_q   <= retire_d;
      misalign_q <= misalign_d;
      bad_pc_q   <= bad_pc_d;
    end
  end

  // Valids are gated by reset so nothing is offered while reset is held.
  assign bus.imem_req_valid_o = rst_n_i && (state_q == StReq);
  assign bus.imem_addr_o      = pc_q;
  assign bus.inst_valid_o     = rst_n_i && (state_q == StIssue);
  assign bus.inst_o           = ir_q;
  assign bus.inst_pc_o        = pc_q;
  assign bus.busy_o           = (state_q != StIdle) && (state_q != StHalt);
  assign bus.misalign_o       = misalign_q;
  assign bus.bad_pc_o         = bad_pc_q;
  assign bus.retire_cnt_o     = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a transaction-phase model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_pc_sequencer;
  localparam int unsigned DW = 64;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  pc_sequencer #(.DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus.master)
  );

  int total = 0;
  int bad   = 0;

  // Environment: next-PC unit returns pc+4 unless a forced value is requested.
  logic        pcn_force = 1'b0;
  logic [63:0] pcn_val   = '0;
  logic [31:0] rsp_word  = 32'h1357_9bdf;
  assign bus.pcn_i           = pcn_force ? pcn_val : bus.inst_pc_o + 64'd4;
  assign bus.imem_rsp_data_i = rsp_word;

  always @(posedge clk) rsp_word <= {rsp_word[30:0], rsp_word[31] ^ rsp_word[21] ^ rsp_word[1]};

  // Fetch log of accepted requests with the cycle they were accepted in.
  logic [63:0] fetch_addr[$];
  int          fetch_cyc[$];
  int          cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.imem_req_valid_o && bus.imem_req_ready_i) begin
      fetch_addr.push_back(bus.imem_addr_o);
      fetch_cyc.push_back(cyc);
    end
  end

  // Behavioural model: phase of the current instruction transaction.
  localparam int PIdle = 0, PFetch = 1, PMem = 2, POffer = 3, PResolve = 4, PDead = 5;
  int          m_ph  = PIdle;
  logic [63:0] m_pc  = '0;
  logic [31:0] m_ir  = '0;
  logic [63:0] m_cnt = '0;
  logic        m_mis = 1'b0;
  logic [63:0] m_bad = '0;
  logic        m_ok  = 1'b0;

  // Advance the model with the same inputs the DUT sees at the edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph <= PIdle; m_pc <= RST_PC; m_ir <= '0; m_cnt <= '0;
      m_mis <= 1'b0; m_bad <= '0; m_ok <= 1'b1;
    end else if (m_ph == PIdle) begin
      if (!bus.halt_req_i) m_ph <= PFetch;
    end else if (m_ph == PFetch) begin
      if (bus.imem_req_ready_i) m_ph <= PMem;
    end else if (m_ph == PMem) begin
      if (bus.imem_rsp_valid_i) begin m_ir <= bus.imem_rsp_data_i; m_ph <= POffer; end
    end else if (m_ph == POffer) begin
      if (bus.inst_ready_i) m_ph <= PResolve;
    end else if (m_ph == PResolve && bus.pcn_valid_i) begin
      if (bus.pcn_i % 4 == 0) begin
        m_pc <= bus.pcn_i; m_cnt <= m_cnt + 64'd1;
        m_ph <= bus.halt_req_i ? PIdle : PFetch;
      end else begin
        m_mis <= 1'b1; m_bad <= bus.pcn_i; m_ph <= PDead;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("req_valid", 64'(bus.imem_req_valid_o), 64'(rst_n && m_ph == PFetch));
      check("inst_valid", 64'(bus.inst_valid_o), 64'(rst_n && m_ph == POffer));
      check("busy", 64'(bus.busy_o), 64'(m_ph != PIdle && m_ph != PDead));
      check("retire_cnt", bus.retire_cnt_o, m_cnt);
      check("misalign", 64'(bus.misalign_o), 64'(m_mis));
      check("bad_pc", bus.bad_pc_o, m_bad);
      if (m_ph == PFetch) check("imem_addr", bus.imem_addr_o, m_pc);
      if (m_ph == POffer || m_ph == PResolve) check("inst_pc", bus.inst_pc_o, m_pc);
      if (m_ph == POffer) check("inst", 64'(bus.inst_o), 64'(m_ir));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fetches(input int n, input int budget);
    int k = 0;
    while (fetch_addr.size() < n && k < budget) begin tick(1); k++; end
    if (fetch_addr.size() < n) begin
      total++; bad++;
      $display("FAIL fetch_timeout: got=%0d want=%0d fetches", fetch_addr.size(), n);
    end
  endtask

  int n0;

  initial begin
    rst_n = 1'b0;
    bus.halt_req_i = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    bus.imem_rsp_valid_i = 1'b1;
    bus.inst_ready_i = 1'b1;
    bus.pcn_valid_i = 1'b1;
    tick(3);
    check("rst_retire", bus.retire_cnt_o, 64'd0);
    check("rst_req_valid", 64'(bus.imem_req_valid_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);

    // Back-to-back loop; halt during the third fetch's WAIT.
    rst_n = 1'b1;
    tick(1);
    check("first_req_valid", 64'(bus.imem_req_valid_o), 64'd1);
    check("first_addr", bus.imem_addr_o, 64'h8000_0000);
    tick(9);
    bus.halt_req_i = 1'b1;
    tick(5);
    check("loop_retire", bus.retire_cnt_o, 64'd3);
    check("halt_busy", 64'(bus.busy_o), 64'd0);
    check("loop_fetches", 64'(fetch_addr.size()), 64'd3);
    if (fetch_addr.size() == 3) begin
      check("fetch0", fetch_addr[0], 64'h8000_0000);
      check("fetch1", fetch_addr[1], 64'h8000_0004);
      check("fetch2", fetch_addr[2], 64'h8000_0008);
      check("cadence01", 64'(fetch_cyc[1] - fetch_cyc[0]), 64'd4);
      check("cadence12", 64'(fetch_cyc[2] - fetch_cyc[1]), 64'd4);
    end

    // Request stall: ready low for 5 cycles in REQ.
    bus.imem_req_ready_i = 1'b0;
    bus.inst_ready_i = 1'b0;
    bus.halt_req_i = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(bus.imem_req_valid_o), 64'd1);
      check("stall_addr", bus.imem_addr_o, 64'h8000_000c);
      tick(1);
    end
    check("stall_fetches", 64'(fetch_addr.size()), 64'd3);

    // Issue stall with misaligned next-PC pulses that must be ignored.
    bus.imem_req_ready_i = 1'b1;
    for (int k = 0; k < 10 && !bus.inst_valid_o; k++) tick(1);
    pcn_force = 1'b1;
    pcn_val = 64'hdead_0003;
    for (int i = 0; i < 3; i++) begin
      check("issue_valid", 64'(bus.inst_valid_o), 64'd1);
      check("issue_pc", bus.inst_pc_o, 64'h8000_000c);
      tick(1);
    end
    check("issue_misalign", 64'(bus.misalign_o), 64'd0);
    pcn_force = 1'b0;
    bus.inst_ready_i = 1'b1;
    wait_fetches(5, 20);
    if (fetch_addr.size() >= 5) check("after_issue_fetch", fetch_addr[4], 64'h8000_0010);
    check("after_issue_retire", bus.retire_cnt_o, 64'd4);

    // Reset in EXEC with retire count 7.
    for (int k = 0; k < 60 && bus.retire_cnt_o != 64'd7; k++) tick(1);
    check("reach_seven", bus.retire_cnt_o, 64'd7);
    bus.pcn_valid_i = 1'b0;
    for (int k = 0; k < 10 && !bus.inst_valid_o; k++) tick(1);
    tick(1);
    check("exec_pc", bus.inst_pc_o, 64'h8000_001c);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    bus.pcn_valid_i = 1'b1;
    check("midrst_retire", bus.retire_cnt_o, 64'd0);
    n0 = fetch_addr.size();
    wait_fetches(n0 + 1, 10);
    if (fetch_addr.size() > n0) check("refetch", fetch_addr[n0], 64'h8000_0000);

    // Misaligned target is terminal.
    pcn_force = 1'b1;
    pcn_val = 64'h8000_0102;
    for (int k = 0; k < 20 && !bus.misalign_o; k++) tick(1);
    n0 = fetch_addr.size();
    bus.halt_req_i = 1'b1;
    tick(3);
    bus.halt_req_i = 1'b0;
    pcn_val = 64'h8000_0200;
    tick(12);
    check("mis_flag", 64'(bus.misalign_o), 64'd1);
    check("mis_bad_pc", bus.bad_pc_o, 64'h8000_0102);
    check("mis_busy", 64'(bus.busy_o), 64'd0);
    check("mis_retire", bus.retire_cnt_o, 64'd0);
    check("mis_no_fetch", 64'(fetch_addr.size()), 64'(n0));
    check("mis_req_valid", 64'(bus.imem_req_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
